// File: rtl/cpu_defs.sv
// Shared fetch-path types and constants.
// Slot layout for the in-flight fetch ring.
package cpu_defs;

    localparam int FETCH_CHANNEL    = 4;
    localparam int FETCH_DATA_WIDTH = 32;
    localparam int FETCH_OFF_W      = $clog2(FETCH_CHANNEL);
    localparam int GROUP_BYTES      = FETCH_CHANNEL * 4;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc00000;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_WAIT,
        SLOT_FULL
    } fetch_slot_state_t;

    typedef struct packed {
        fetch_slot_state_t                           state;
        logic [FETCH_OFF_W-1:0]                      offset;
        logic [FETCH_CHANNEL*FETCH_DATA_WIDTH-1:0]   data;
    } fetch_slot_t;

endpackage

// File: rtl/fetch_inflight_ring.sv
// Ring of in-flight fetch slots: allocated on request,
// filled in order by responses, freed from the head on push.
module fetch_inflight_ring
    import cpu_defs::*;
#(
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      clear,
    input  logic                                      alloc,
    input  logic [FETCH_OFF_W-1:0]                    alloc_offset,
    input  logic                                      fill,
    input  logic [FETCH_CHANNEL*FETCH_DATA_WIDTH-1:0] fill_data,
    input  logic                                      free,
    output fetch_slot_t                               head_slot,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]         count,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]         wait_count
);

    localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    fetch_slot_t      slots [MAX_INFLIGHT];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    fptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + PW'(1);
    endfunction

    // WAIT slots sit contiguously between fptr and tail, so fills
    // always land on the oldest outstanding request.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                slots[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            fptr  <= '0;
            count <= '0;
        end else begin
            if (alloc) begin
                slots[tail].state  <= SLOT_WAIT;
                slots[tail].offset <= alloc_offset;
                tail               <= nxt(tail);
            end
            if (fill) begin
                slots[fptr].state <= SLOT_FULL;
                slots[fptr].data  <= fill_data;
                fptr              <= nxt(fptr);
            end
            if (free) begin
                slots[head].state <= SLOT_FREE;
                head              <= nxt(head);
            end
            count <= count + CW'(alloc) - CW'(free);
        end
    end

    always_comb begin
        wait_count = '0;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            if (slots[i].state == SLOT_WAIT) begin
                wait_count = wait_count + CW'(1);
            end
        end
    end

    assign head_slot = slots[head];

    fill_needs_wait: assert property (
        @(posedge clk) disable iff (rst || clear)
        fill |-> (slots[fptr].state == SLOT_WAIT)
    );

endmodule

// File: rtl/fetch_group_feeder.sv
// Fetch PC owner: issues group-aligned I-cache requests and pushes
// returned groups into the fetch queue as lane-aligned bursts.
module fetch_group_feeder
    import cpu_defs::*;
#(
    parameter int                 CHANNEL      = FETCH_CHANNEL,
    parameter int                 DATA_WIDTH   = FETCH_DATA_WIDTH,
    parameter int                 ADDR_WIDTH   = 32,
    parameter int                 MAX_INFLIGHT = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = DEFAULT_RESET_PC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [ADDR_WIDTH-1:0]         flush_pc,
    output logic                          icache_req_valid,
    output logic [ADDR_WIDTH-1:0]         icache_req_addr,
    input  logic                          icache_req_ready,
    input  logic                          icache_resp_valid,
    input  logic [CHANNEL*DATA_WIDTH-1:0] icache_resp_data,
    input  logic                          queue_ready,
    output logic [CHANNEL*DATA_WIDTH-1:0] data_push,
    output logic [$clog2(CHANNEL+1)-1:0]  push_num,
    output logic [$clog2(CHANNEL+1)-1:0]  push_offset
);

    localparam int LG   = $clog2(CHANNEL);
    localparam int NW   = $clog2(CHANNEL + 1);
    localparam int CW   = $clog2(MAX_INFLIGHT + 1);
    localparam int DCW  = $clog2(MAX_INFLIGHT * 2 + 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~ADDR_WIDTH'(GROUP_BYTES - 1);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] aligned_pc;
    logic [DCW-1:0]        discard;
    fetch_slot_t           head_slot;
    logic [CW-1:0]         count;
    logic [CW-1:0]         wait_count;
    logic                  req_fire;
    logic                  resp_fill;
    logic                  push;

    assign aligned_pc       = pc & ALIGN_MASK;
    assign icache_req_addr  = aligned_pc;
    assign icache_req_valid = ~rst & ~flush & (count < CW'(MAX_INFLIGHT));
    assign req_fire         = icache_req_valid & icache_req_ready;

    // Responses owed to requests killed by a flush are swallowed first.
    assign resp_fill = icache_resp_valid & ~flush & ~rst & (discard == '0);

    assign push = ~rst & ~flush & queue_ready
                & (head_slot.state == SLOT_FULL);

    assign push_num    = push ? NW'(CHANNEL) - NW'(head_slot.offset) : '0;
    assign push_offset = push ? NW'(head_slot.offset) : '0;
    assign data_push   = push ? head_slot.data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            discard <= '0;
        end else if (flush) begin
            pc      <= flush_pc;
            discard <= discard + DCW'(wait_count)
                     - DCW'(icache_resp_valid);
        end else begin
            if (req_fire) begin
                pc <= aligned_pc + ADDR_WIDTH'(GROUP_BYTES);
            end
            if (icache_resp_valid && discard != '0) begin
                discard <= discard - DCW'(1);
            end
        end
    end

    fetch_inflight_ring #(
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_ring (
        .clk          (clk),
        .rst          (rst),
        .clear        (flush),
        .alloc        (req_fire),
        .alloc_offset (pc[LG+1:2]),
        .fill         (resp_fill),
        .fill_data    (icache_resp_data),
        .free         (push),
        .head_slot    (head_slot),
        .count        (count),
        .wait_count   (wait_count)
    );

endmodule

// File: tb/tb_fetch_group_feeder.sv
// Bench for fetch_group_feeder: directed vector table followed by
// randomized traffic checked against a queue-based reference model.
module tb_fetch_group_feeder;

    localparam int CH = 4;
    localparam int MI = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [31:0]   flush_pc;
    logic          icache_req_valid;
    logic [31:0]   icache_req_addr;
    logic          icache_req_ready;
    logic          icache_resp_valid;
    logic [127:0]  icache_resp_data;
    logic          queue_ready;
    logic [127:0]  data_push;
    logic [2:0]    push_num;
    logic [2:0]    push_offset;

    always #5 clk = ~clk;

    fetch_group_feeder dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .icache_req_valid  (icache_req_valid),
        .icache_req_addr   (icache_req_addr),
        .icache_req_ready  (icache_req_ready),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_data  (icache_resp_data),
        .queue_ready       (queue_ready),
        .data_push         (data_push),
        .push_num          (push_num),
        .push_offset       (push_offset)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] grp(input int tag);
        logic [127:0] d;
        for (int l = 0; l < CH; l++) begin
            d[l*32 +: 32] = 32'hd000_0000 | (32'(tag) << 8) | 32'(l);
        end
        return d;
    endfunction

    typedef struct {
        bit          r;
        bit          f;
        logic [31:0] fpc;
        bit          rr;
        bit          rv;
        bit          qr;
        bit          erv;
        logic [31:0] ea;
        int          en;
        int          eo;
        int          et;
    } vec_t;

    vec_t tv[$];

    function automatic void add(bit r, bit f, logic [31:0] fpc, bit rr,
                                bit rv, bit qr, bit erv,
                                logic [31:0] ea, int en, int eo, int et);
        tv.push_back('{r, f, fpc, rr, rv, qr, erv, ea, en, eo, et});
    endfunction

    typedef struct {
        logic [1:0]   off;
        bit           full;
        logic [127:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;
    int          mdisc;

    function automatic int n_wait();
        int n = 0;
        foreach (mq[i]) if (!mq[i].full) n++;
        return n;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; flush_pc = '0;
        icache_req_ready = 1'b0; icache_resp_valid = 1'b0;
        icache_resp_data = '0; queue_ready = 1'b1;

        // r  f  fpc           rr rv qr erv ea            num off tag
        add(1, 0, 32'h0,        0, 0, 1, 0, 32'h0,        0, 0, 0);
        add(1, 0, 32'h0,        0, 0, 1, 0, 32'h0,        0, 0, 0);
        add(0, 0, 32'h0,        1, 0, 1, 1, 32'hbfc00000, 0, 0, 0);
        add(0, 0, 32'h0,        1, 0, 1, 1, 32'hbfc00010, 0, 0, 0);
        add(0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 0, 0);
        add(0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        4, 0, 4);
        add(0, 0, 32'h0,        1, 0, 1, 1, 32'hbfc00020, 4, 0, 5);
        add(0, 1, 32'h80000008, 1, 0, 1, 0, 32'h0,        0, 0, 0);
        add(0, 0, 32'h0,        1, 1, 1, 1, 32'h80000000, 0, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 1, 32'h80000010, 0, 0, 0);
        add(0, 0, 32'h0,        0, 0, 1, 1, 32'h80000010, 2, 2, 9);
        add(0, 0, 32'h0,        1, 0, 0, 1, 32'h80000010, 0, 0, 0);
        add(0, 0, 32'h0,        1, 1, 0, 1, 32'h80000020, 0, 0, 0);
        add(0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        0, 0, 0);
        add(0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        0, 0, 0);
        add(0, 0, 32'h0,        1, 0, 1, 0, 32'h0,        4, 0, 12);
        add(0, 0, 32'h0,        1, 0, 1, 1, 32'h80000030, 4, 0, 13);
        add(0, 0, 32'h0,        1, 0, 1, 1, 32'h80000040, 0, 0, 0);
        add(0, 1, 32'h00001004, 1, 0, 1, 0, 32'h0,        0, 0, 0);
        add(0, 0, 32'h0,        1, 1, 1, 1, 32'h00001000, 0, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 1, 32'h00001010, 0, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 1, 32'h00001010, 0, 0, 0);
        add(0, 0, 32'h0,        0, 0, 1, 1, 32'h00001010, 3, 1, 21);
        add(0, 0, 32'h0,        1, 0, 1, 1, 32'h00001010, 0, 0, 0);
        add(0, 0, 32'h0,        1, 0, 1, 1, 32'h00001020, 0, 0, 0);
        add(0, 1, 32'h00002000, 1, 1, 1, 0, 32'h0,        0, 0, 0);
        add(0, 0, 32'h0,        1, 1, 1, 1, 32'h00002000, 0, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 1, 32'h00002010, 0, 0, 0);
        add(0, 0, 32'h0,        1, 0, 1, 1, 32'h00002010, 4, 0, 27);
        add(0, 0, 32'h0,        1, 1, 0, 1, 32'h00002020, 0, 0, 0);
        add(0, 0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 0, 0);
        add(1, 0, 32'h0,        1, 0, 1, 0, 32'h0,        0, 0, 0);
        add(0, 0, 32'h0,        0, 0, 1, 1, 32'hbfc00000, 0, 0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            rst               = tv[i].r;
            flush             = tv[i].f;
            flush_pc          = tv[i].fpc;
            icache_req_ready  = tv[i].rr;
            icache_resp_valid = tv[i].rv;
            icache_resp_data  = grp(i);
            queue_ready       = tv[i].qr;
            @(negedge clk);
            chk($sformatf("vec%0d req_valid", i),
                128'(icache_req_valid), 128'(tv[i].erv));
            if (tv[i].erv)
                chk($sformatf("vec%0d req_addr", i),
                    128'(icache_req_addr), 128'(tv[i].ea));
            chk($sformatf("vec%0d push_num", i),
                128'(push_num), 128'(tv[i].en));
            chk($sformatf("vec%0d push_offset", i),
                128'(push_offset), 128'(tv[i].eo));
            if (tv[i].en != 0)
                chk($sformatf("vec%0d data_push", i),
                    data_push, grp(tv[i].et));
            else if (tv[i].r)
                chk($sformatf("vec%0d data_push_rst", i), data_push, '0);
            @(posedge clk);
            #1;
        end

        mq.delete();
        mpc   = 32'hbfc00000;
        mdisc = 0;
        for (int c = 0; c < 3000; c++) begin
            bit           legal;
            bit           erv;
            bit           epush;
            int           enum_v;
            int           eoff;
            logic [127:0] edata;

            legal             = (mdisc > 0) || (n_wait() > 0);
            rst               = (c == 0) || ($urandom % 64 == 0);
            flush             = !rst && ($urandom % 12 == 0);
            flush_pc          = $urandom;
            icache_req_ready  = ($urandom % 3) != 0;
            queue_ready       = ($urandom % 4) != 0;
            icache_resp_valid = !rst && legal && ($urandom % 2 == 1);
            icache_resp_data  = {$urandom, $urandom, $urandom, $urandom};

            erv    = !rst && !flush && (mq.size() < MI);
            epush  = !rst && !flush && queue_ready
                   && (mq.size() > 0) && mq[0].full;
            enum_v = epush ? CH - int'(mq[0].off) : 0;
            eoff   = epush ? int'(mq[0].off) : 0;
            edata  = epush ? mq[0].data : '0;

            @(negedge clk);
            chk("rnd req_valid", 128'(icache_req_valid), 128'(erv));
            if (erv)
                chk("rnd req_addr", 128'(icache_req_addr),
                    128'(mpc & ~32'hf));
            chk("rnd push_num", 128'(push_num), 128'(enum_v));
            chk("rnd push_offset", 128'(push_offset), 128'(eoff));
            if (epush || rst)
                chk("rnd data_push", data_push, edata);

            if (rst) begin
                mq.delete();
                mpc   = 32'hbfc00000;
                mdisc = 0;
            end else if (flush) begin
                mdisc = mdisc + n_wait() - int'(icache_resp_valid);
                mq.delete();
                mpc = flush_pc;
            end else begin
                if (icache_resp_valid) begin
                    if (mdisc > 0) begin
                        mdisc--;
                    end else begin
                        for (int k = 0; k < mq.size(); k++) begin
                            if (!mq[k].full) begin
                                mq[k].full = 1'b1;
                                mq[k].data = icache_resp_data;
                                break;
                            end
                        end
                    end
                end
                if (epush) void'(mq.pop_front());
                if (erv && icache_req_ready) begin
                    mq.push_back('{mpc[3:2], 1'b0, 128'h0});
                    mpc = (mpc & ~32'hf) + 32'h10;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_group_feeder.md
Name: fetch_group_feeder

Overview:
Upstream neighbour of the instruction fetch queue (multi_queue). It owns the fetch PC and issues group-aligned requests to the I-cache. It tracks in-flight requests and buffers returned fetch groups. Each group is pushed into the queue as a lane-aligned burst (data_push, push_num, push_offset), so entry into a group mid-line drops the leading lanes.

Parameters:
CHANNEL, 4, instructions per fetch group; power of two; equals the queue's CHANNEL
DATA_WIDTH, 32, instruction width
ADDR_WIDTH, 32, PC width
MAX_INFLIGHT, 2, slots covering issued-but-unpushed groups; power of two
RESET_PC, 32'hbfc00000, PC after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  redirect, one-cycle pulse
flush_pc  in  ADDR_WIDTH  redirect target, valid with flush
icache_req_valid  out  1  request valid
icache_req_addr  out  ADDR_WIDTH  group-aligned request address
icache_req_ready  in  1  I-cache accepts request
icache_resp_valid  in  1  in-order response strobe
icache_resp_data  in  CHANNEL*DATA_WIDTH  group data; lane i = word i
queue_ready  in  1  queue can accept CHANNEL entries this cycle (~full)
data_push  out  CHANNEL*DATA_WIDTH  lane data to queue
push_num  out  $clog2(CHANNEL+1)  entries pushed this cycle; 0 = none
push_offset  out  $clog2(CHANNEL+1)  first pushed lane

Behaviour:
- Constants: G = CHANNEL*4 bytes; LG = log2(CHANNEL).
- Reset: pc=RESET_PC, all slots free, discard=0. Outputs while rst is high: req_valid=0, push_num=0, push_offset=0, data_push=0.
- Request address: icache_req_addr = pc with bits [LG+1:0] cleared.
- Request valid: icache_req_valid = ~flush & (occupied slots < MAX_INFLIGHT).
- Handshake: addr is held stable while valid & ~ready. Only flush or rst may retract it.
- Request fire (valid & ready):
  - Allocate the tail slot with state WAIT and offset = pc[LG+1:2].
  - pc <= aligned pc + G.
- Response fill: a response with discard==0 fills the oldest WAIT slot and marks it FULL. A response with no WAIT slot is a protocol error; assert in simulation.
- Discard: a response with discard>0 is dropped and discard decrements.
- Push timing: push is combinational from the head slot. The earliest push is the cycle after the response arrives (one-cycle fill latency).
- Push condition: the head slot is FULL & queue_ready & ~flush.
- Push values:
  - push_offset = head offset.
  - push_num = CHANNEL - offset.
  - data_push = head data, all lanes. Lanes below the offset are don't-care but are driven from the stored data.
  - The head slot is freed on push.
- No push: push_num=0 and push_offset=0.
- Ring: head and tail wrap modulo MAX_INFLIGHT.
- A slot freed by a push and a new request allocated in the same cycle are both legal. The occupancy count uses the pre-update value, so a full ring does not issue in the cycle it frees.
- Flush (takes priority over everything except rst):
  - All slots are freed.
  - pc <= flush_pc.
  - No push and no request in the flush cycle.
  - discard <= discard + (number of WAIT slots) - (icache_resp_valid ? 1 : 0). A response in the flush cycle is dropped.
  - A request that was handshaking in the flush cycle is not counted.
- Flush while discard>0 accumulates into discard. discard width is $clog2(MAX_INFLIGHT*2+1).
- After flush, the first request is at flush_pc aligned, with offset = flush_pc[LG+1:2].
- A stalled queue (queue_ready=0) holds FULL slots. Requests continue until MAX_INFLIGHT slots are occupied.
- rst mid-operation: state returns to reset values next edge. Outstanding I-cache responses are the I-cache's responsibility because it is reset by the same rst.

Decomposition:
- Package (cpu_defs): fetch_slot_state_t enum {SLOT_FREE, SLOT_WAIT, SLOT_FULL}.
- Package (cpu_defs): fetch_slot_t struct {state, offset, data}.
- Package (cpu_defs): the group-size byte constant and the default RESET_PC.
- Sub-module fetch_inflight_ring: the MAX_INFLIGHT slot ring with alloc, fill and free ports and the occupancy count. The top level keeps the PC, discard counter and push formatting.

Test Plan:
- Reset release, icache_req_ready=1 -> first request addr 32'hbfc00000, next 32'hbfc00010. After two responses, the pushes are push_num=4 and push_offset=0 each.
- flush with flush_pc=32'h80000008, then response -> request 32'h80000000; pushed with push_num=2, push_offset=2, lanes 2..3 = resp words 2..3.
- queue_ready=0, req_ready=1 -> exactly 2 requests issued, then req_valid=0. After queue_ready=1 the slots drain in order, one per cycle, and requests resume.
- 2 requests outstanding, flush, then 2 stale responses -> neither is pushed and discard returns to 0. The third response fills the flush_pc slot.
- flush coincident with icache_resp_valid and 2 WAIT slots -> discard=1 and the coincident response is dropped. Next response dropped, following response accepted.
- rst asserted with 2 FULL slots -> next cycle push_num=0, req_addr=32'hbfc00000.
